pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It drives the `we`/`clear` pairs of the F/D/E/M/W pipeline registers and the PC write enable. It resolves load-use hazards, multi-cycle MULT/DIV occupancy of HI/LO, data-memory wait states and exception/ERET redirection. It sits beside the hazard/forwarding logic in the datapath top level and is the only source of pipeline-register control.

## Interface
- `MUL_LAT`, 5: cycles HI/LO is busy after a MULT/MULTU leaves E.
- `DIV_LAT`, 32: cycles HI/LO is busy after a DIV/DIVU leaves E; must be ≤63.
- `FLUSH_CYC`, 2: post-exception bubble cycles, during which CP0 settles EPC/Status; must be ≥1.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rs_d`, `rt_d` in 5: source register numbers of the instruction in D.
- `ex_is_load` in 1: E holds a load.
- `ex_rt` in 5: destination of the load in E.
- `md_start_e` in 1: E holds MULT/MULTU/DIV/DIVU.
- `md_is_div` in 1: qualifies `md_start_e`.
- `md_use_d` in 1: the D instruction reads or writes HI/LO, or is a mult/div.
- `mem_stall` in 1: data memory is not ready for the M access.
- `exc_m` in 1: exception or ERET is committed in M.
- `pc_we` out 1: PC write enable.
- `pc_sel_exc` out 1: PC mux selects the CP0 vector/EPC.
- `we_d`, `we_e`, `we_m`, `we_w` out 1 each: pipeline register write enables.
- `clr_d`, `clr_e`, `clr_m`, `clr_w` out 1 each: pipeline register synchronous clears.
- `md_busy` out 1: HI/LO result is pending.
- `md_done` out 1: last busy cycle.
- `md_abort` out 1: in-flight mult/div is cancelled.

## Operation
- State `st` ∈ {RUN, FLUSH}. Counters: `fcnt` (clog2(FLUSH_CYC+1) bits) and `mdcnt` (6 bits).
- **Load-use hazard:** `lu = ex_is_load && ex_rt!=0 && (ex_rt==rs_d || ex_rt==rt_d)`.
- **HI/LO hazard:** `mdh = md_busy && md_use_d`.
- Default in RUN: all `we_*`=1, `pc_we`=1, all `clr_*`=0, `pc_sel_exc`=0.
- Priority, highest first:
  1. **exc_m in RUN:** `pc_we`=1, `pc_sel_exc`=1, and `clr_d`, `clr_e`, `clr_m`, `clr_w`=1. The excepting instruction and all younger ones are squashed. `md_abort`=1 if `md_busy`, and `mdcnt`←0. Next `st`=FLUSH, `fcnt`←FLUSH_CYC.
  2. **mem_stall:** `pc_we`, `we_d`, `we_e`, `we_m`=0 and `clr_w`=1, so a bubble enters W.
  3. **mdh or lu:** `pc_we`, `we_d`=0 and `clr_e`=1, so a bubble enters E. M and W advance.
- **FLUSH:**
  - `pc_we`=0 and `clr_d`=1. Other stages advance.
  - `exc_m` and `md_start_e` are ignored.
  - `fcnt` decrements each cycle; `fcnt`==1 → next `st`=RUN.
  - `mem_stall` is also ignored, because M holds only a bubble.
- **MD counter:**
  - Load condition: `md_start_e && we_m && !clr_m` in RUN.
  - On load, `mdcnt` ← DIV_LAT if `md_is_div`, else MUL_LAT.
  - Otherwise `mdcnt` decrements while nonzero. It keeps decrementing during `mem_stall`.
  - `md_busy` = (`mdcnt`!=0).
  - `md_done` = (`mdcnt`==1).
- **Simultaneous load and decrement:** load wins. This cannot occur legally, because `mdh` blocks a second mult/div in D.
- **Reset:** while `rst`=0, regardless of clock:
  - `st`=RUN, `fcnt`=0, `mdcnt`=0.
  - All `we_*` and `pc_we` are 0; all `clr_*` are 1.
  - `pc_sel_exc`, `md_busy`, `md_done` and `md_abort` are 0.
- **Reset deasserted mid-flush:** the block returns to RUN. Any pending mult/div is lost.

## Timing
- All hazard outputs are combinational from inputs and state, valid in the same cycle. There are no registered outputs apart from the state-derived terms.
- **Load-use:** exactly 1 stall cycle, because `ex_is_load` drops once the load leaves E.
- **Mult/div:** an instruction leaving E at edge N makes `md_busy` high for cycles N+1 through N+LAT. A dependent instruction in D is released in cycle N+LAT+1.
- **Exception:** the redirect happens in the `exc_m` cycle, followed by FLUSH_CYC bubble cycles. The handler's first instruction enters D FLUSH_CYC+1 cycles after the `exc_m` cycle.
- **mem_stall:** zero latency. Stalls last exactly as long as the input is asserted.

## Structure
- A shared `pipe_ctrl_pkg` holds the `st` encoding (RUN=0, FLUSH=1) and the default latency constants.
- One sub-module, `md_busy_cnt`, contains `mdcnt`, its load/abort logic and `md_busy`/`md_done`. The FSM and priority logic stay in the top module.

## Test plan
- **Load-use, rs match:** `ex_is_load`=1, `ex_rt`=8, `rs_d`=8 for 1 cycle → `pc_we`=`we_d`=0, `clr_e`=1 for that cycle; `ex_rt`=0 gives no stall.
- **MULT then MFHI:** `md_start_e`=1, `md_is_div`=0 → `md_busy` for 5 cycles and `md_done` in the 5th. Hold `md_use_d`=1 → `we_d`=0 for those 5 cycles, released in the 6th.
- **DIV aborted:** DIV issued, then `exc_m` at busy cycle 10 → `md_abort`=1 and `md_busy`=0 from the next cycle. `pc_sel_exc`=1 and `clr_d`..`clr_w`=1 in that cycle, then 2 cycles with `pc_we`=0 and `clr_d`=1, then RUN.
- **mem_stall together with lu:** `mem_stall` and `lu` both asserted for 3 cycles → `pc_we`/`we_d`/`we_e`/`we_m`=0, `clr_w`=1 and `clr_e`=0 each cycle. `lu` takes effect after release.
- **exc_m during FLUSH:** `exc_m` pulsed during FLUSH → ignored, and FLUSH still ends after FLUSH_CYC cycles.
- **Reset mid-operation:** async `rst`=0 mid-FLUSH with `mdcnt`=17 → outputs reach reset values immediately without a clock. After release the block is in RUN with `md_busy`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and default latencies for the pipeline stall/flush controller.
package pipe_ctrl_pkg;
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } st_t;

  localparam int DEF_MUL_LAT   = 5;
  localparam int DEF_DIV_LAT   = 32;
  localparam int DEF_FLUSH_CYC = 2;
  localparam int MDCNT_W       = 6;
endpackage

// File: rtl/md_busy_cnt.sv
// HI/LO occupancy counter: loaded when a mult/div leaves E, counts down to idle.
module md_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic is_div,
  input  logic abort,
  output logic busy,
  output logic done
);
  logic [MDCNT_W-1:0] mdcnt_reg, mdcnt_next;

  always_comb begin
    mdcnt_next = mdcnt_reg;
    if (abort) begin
      mdcnt_next = '0;
    end else if (load) begin
      mdcnt_next = is_div ? MDCNT_W'(DIV_LAT) : MDCNT_W'(MUL_LAT);
    end else if (mdcnt_reg != '0) begin
      mdcnt_next = mdcnt_reg - MDCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdcnt_reg <= '0;
    end else begin
      mdcnt_reg <= mdcnt_next;
    end
  end

  assign busy = (mdcnt_reg != '0);
  assign done = (mdcnt_reg == MDCNT_W'(1));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, HI/LO busy,
// memory wait states and exception redirect with a post-exception flush window.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT   = DEF_MUL_LAT,
  parameter int DIV_LAT   = DEF_DIV_LAT,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rt,
  input  logic       md_start_e,
  input  logic       md_is_div,
  input  logic       md_use_d,
  input  logic       mem_stall,
  input  logic       exc_m,
  output logic       pc_we,
  output logic       pc_sel_exc,
  output logic       we_d,
  output logic       we_e,
  output logic       we_m,
  output logic       we_w,
  output logic       clr_d,
  output logic       clr_e,
  output logic       clr_m,
  output logic       clr_w,
  output logic       md_busy,
  output logic       md_done,
  output logic       md_abort
);
  localparam int FCNT_W = $clog2(FLUSH_CYC + 1);

  st_t               st_reg, st_next;
  logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
  logic              lu, mdh, md_load, md_clear;

  assign lu  = ex_is_load && (ex_rt != 5'd0) && ((ex_rt == rs_d) || (ex_rt == rt_d));
  assign mdh = md_busy && md_use_d;

  always_comb begin
    st_next    = st_reg;
    fcnt_next  = fcnt_reg;
    pc_we      = 1'b1;
    pc_sel_exc = 1'b0;
    we_d       = 1'b1;
    we_e       = 1'b1;
    we_m       = 1'b1;
    we_w       = 1'b1;
    clr_d      = 1'b0;
    clr_e      = 1'b0;
    clr_m      = 1'b0;
    clr_w      = 1'b0;
    md_abort   = 1'b0;
    md_clear   = 1'b0;
    case (st_reg)
      ST_RUN: begin
        if (exc_m) begin
          pc_sel_exc = 1'b1;
          clr_d      = 1'b1;
          clr_e      = 1'b1;
          clr_m      = 1'b1;
          clr_w      = 1'b1;
          md_abort   = md_busy;
          md_clear   = 1'b1;
          st_next    = ST_FLUSH;
          fcnt_next  = FCNT_W'(FLUSH_CYC);
        end else if (mem_stall) begin
          pc_we = 1'b0;
          we_d  = 1'b0;
          we_e  = 1'b0;
          we_m  = 1'b0;
          clr_w = 1'b1;
        end else if (mdh || lu) begin
          pc_we = 1'b0;
          we_d  = 1'b0;
          clr_e = 1'b1;
        end
      end
      ST_FLUSH: begin
        // M holds only a bubble here, so exc_m, mem_stall and md_start_e are don't-cares
        pc_we     = 1'b0;
        clr_d     = 1'b1;
        fcnt_next = fcnt_reg - FCNT_W'(1);
        if (fcnt_reg == FCNT_W'(1)) begin
          st_next = ST_RUN;
        end
      end
      default: st_next = ST_RUN;
    endcase
    if (!rst) begin
      pc_we      = 1'b0;
      pc_sel_exc = 1'b0;
      we_d       = 1'b0;
      we_e       = 1'b0;
      we_m       = 1'b0;
      we_w       = 1'b0;
      clr_d      = 1'b1;
      clr_e      = 1'b1;
      clr_m      = 1'b1;
      clr_w      = 1'b1;
      md_abort   = 1'b0;
    end
  end

  assign md_load = (st_reg == ST_RUN) && md_start_e && we_m && !clr_m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_reg   <= ST_RUN;
      fcnt_reg <= '0;
    end else begin
      st_reg   <= st_next;
      fcnt_reg <= fcnt_next;
    end
  end

  md_busy_cnt #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_md_busy_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (md_load),
    .is_div(md_is_div),
    .abort (md_clear),
    .busy  (md_busy),
    .done  (md_done)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench: stimulus queues the expected control vector per cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, ex_rt;
  logic       ex_is_load, md_start_e, md_is_div, md_use_d, mem_stall, exc_m;
  logic       pc_we, pc_sel_exc, we_d, we_e, we_m, we_w;
  logic       clr_d, clr_e, clr_m, clr_w, md_busy, md_done, md_abort;
  logic [12:0] got;

  typedef struct {
    logic [12:0] exp;
    string       name;
  } item_t;
  item_t q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .ex_is_load(ex_is_load),
    .ex_rt(ex_rt), .md_start_e(md_start_e), .md_is_div(md_is_div), .md_use_d(md_use_d),
    .mem_stall(mem_stall), .exc_m(exc_m), .pc_we(pc_we), .pc_sel_exc(pc_sel_exc),
    .we_d(we_d), .we_e(we_e), .we_m(we_m), .we_w(we_w), .clr_d(clr_d), .clr_e(clr_e),
    .clr_m(clr_m), .clr_w(clr_w), .md_busy(md_busy), .md_done(md_done), .md_abort(md_abort)
  );

  // {pc_we, pc_sel_exc, we_d,we_e,we_m,we_w, clr_d,clr_e,clr_m,clr_w, busy, done, abort}
  assign got = {pc_we, pc_sel_exc, we_d, we_e, we_m, we_w, clr_d, clr_e, clr_m, clr_w,
                md_busy, md_done, md_abort};

  localparam logic [12:0] V_RST = 13'b0_0_0000_1111_000;

  function automatic logic [12:0] v_run(input logic b, input logic d);
    return {1'b1, 1'b0, 4'b1111, 4'b0000, b, d, 1'b0};
  endfunction
  function automatic logic [12:0] v_lu(input logic b, input logic d);
    return {1'b0, 1'b0, 4'b0111, 4'b0100, b, d, 1'b0};
  endfunction
  function automatic logic [12:0] v_mem(input logic b, input logic d);
    return {1'b0, 1'b0, 4'b0001, 4'b0001, b, d, 1'b0};
  endfunction
  function automatic logic [12:0] v_exc(input logic b);
    return {1'b1, 1'b1, 4'b1111, 4'b1111, b, 1'b0, b};
  endfunction
  function automatic logic [12:0] v_flush();
    return {1'b0, 1'b0, 4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0};
  endfunction

  // Monitor: the DUT presents a control vector every cycle; sample mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if (got !== it.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
      end else begin
        $display("ok   %s: %b", it.name, got);
      end
    end
  end

  task automatic cyc(input string name, input logic [12:0] exp);
    item_t it;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs_d = 5'd0; rt_d = 5'd0; ex_rt = 5'd0; ex_is_load = 1'b0;
    md_start_e = 1'b0; md_is_div = 1'b0; md_use_d = 1'b0;
    mem_stall = 1'b0; exc_m = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    cyc("reset", V_RST);
    rst = 1'b1;
    cyc("idle_run", v_run(0, 0));

    // load-use
    ex_is_load = 1'b1; ex_rt = 5'd8; rs_d = 5'd8;
    cyc("lu_rs", v_lu(0, 0));
    ex_rt = 5'd0; rs_d = 5'd0;
    cyc("lu_r0_nostall", v_run(0, 0));
    ex_rt = 5'd9; rt_d = 5'd9;
    cyc("lu_rt", v_lu(0, 0));
    idle_inputs();
    cyc("lu_release", v_run(0, 0));

    // MULT then MFHI
    md_start_e = 1'b1;
    cyc("mult_issue", v_run(0, 0));
    md_start_e = 1'b0; md_use_d = 1'b1;
    for (int i = 1; i <= 5; i++) cyc($sformatf("mult_busy%0d", i), v_lu(1, i == 5));
    cyc("mult_release", v_run(0, 0));
    idle_inputs();

    // mem_stall dominates load-use
    mem_stall = 1'b1; ex_is_load = 1'b1; ex_rt = 5'd8; rs_d = 5'd8;
    for (int i = 1; i <= 3; i++) cyc($sformatf("mem_lu%0d", i), v_mem(0, 0));
    mem_stall = 1'b0;
    cyc("lu_after_mem", v_lu(0, 0));
    idle_inputs();
    cyc("run_after_lu", v_run(0, 0));

    // DIV aborted by exception at busy cycle 10; md_start_e and mem_stall ignored in FLUSH
    md_start_e = 1'b1; md_is_div = 1'b1;
    cyc("div_issue", v_run(0, 0));
    md_start_e = 1'b0; md_is_div = 1'b0;
    for (int i = 1; i <= 9; i++) cyc($sformatf("div_busy%0d", i), v_run(1, 0));
    exc_m = 1'b1;
    cyc("div_exc_abort", v_exc(1));
    exc_m = 1'b0; md_start_e = 1'b1;
    cyc("flush1_mdstart_ign", v_flush());
    md_start_e = 1'b0; mem_stall = 1'b1;
    cyc("flush2_mem_ign", v_flush());
    mem_stall = 1'b0;
    cyc("post_flush_run", v_run(0, 0));

    // exc_m during FLUSH is ignored
    exc_m = 1'b1;
    cyc("exc2", v_exc(0));
    cyc("exc2_flush1", v_flush());
    cyc("exc2_flush2", v_flush());
    exc_m = 1'b0;
    cyc("exc2_run", v_run(0, 0));

    // mem_stall on issue blocks load; counter decrements through mem_stall
    md_start_e = 1'b1; mem_stall = 1'b1;
    cyc("mult_issue_stalled", v_mem(0, 0));
    mem_stall = 1'b0;
    cyc("mult_issue_go", v_run(0, 0));
    md_start_e = 1'b0; mem_stall = 1'b1;
    for (int i = 1; i <= 5; i++) cyc($sformatf("mult_mem%0d", i), v_mem(1, i == 5));
    mem_stall = 1'b0;
    cyc("mult_mem_done", v_run(0, 0));

    // async reset with mdcnt=17
    md_start_e = 1'b1; md_is_div = 1'b1;
    cyc("div2_issue", v_run(0, 0));
    md_start_e = 1'b0; md_is_div = 1'b0;
    for (int i = 1; i <= 15; i++) cyc($sformatf("div2_busy%0d", i), v_run(1, 0));
    rst = 1'b0;
    cyc("rst_at_cnt17", V_RST);
    rst = 1'b1;
    cyc("rst_release_idle", v_run(0, 0));

    // async reset mid-flush
    exc_m = 1'b1;
    cyc("exc3", v_exc(0));
    exc_m = 1'b0; rst = 1'b0;
    cyc("rst_mid_flush", V_RST);
    rst = 1'b1;
    cyc("rst_flush_release_run", v_run(0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
